// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - shared constants, activation vector type and requant helper
package dnn_pkg;
    localparam int ACC_SIZE = 17;
    localparam int OUT_SIZE = 7;
    localparam int SHIFT    = 6;
    localparam int LANES    = 4;

    localparam logic [OUT_SIZE-1:0] ACT_MAX = OUT_SIZE'((1 << (OUT_SIZE - 1)) - 1);

    typedef logic [LANES-1:0][OUT_SIZE-1:0] act_vec_t;

    typedef struct packed {
        logic                sat;
        logic [OUT_SIZE-1:0] y;
    } lane_res_t;

    // ReLU, round-half-up right shift, clip to ACT_MAX; sat flags a positive clip
    function automatic lane_res_t relu_requant(input logic signed [ACC_SIZE-1:0] acc);
        logic [ACC_SIZE:0] r;
        logic [ACC_SIZE:0] q;
        lane_res_t         res;
        r       = acc[ACC_SIZE-1] ? '0 : {1'b0, acc};
        q       = (r + ((ACC_SIZE + 1)'(1) << (SHIFT - 1))) >> SHIFT;
        res.sat = q > (ACC_SIZE + 1)'(ACT_MAX);
        res.y   = res.sat ? ACT_MAX : q[OUT_SIZE-1:0];
        return res;
    endfunction
endpackage

// File: rtl/dnn_vec_fifo.sv
// rtl/dnn_vec_fifo.sv - synchronous vector FIFO; output holds last head when empty
module dnn_vec_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [WIDTH-1:0] hold_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is still taken when the head leaves on the same edge
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? hold_q : mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            hold_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (!empty)  hold_q <= dout;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end
endmodule

// File: rtl/dnn_act_requant.sv
// rtl/dnn_act_requant.sv - MAC capture, ReLU/requant/saturate, vector FIFO to next layer
module dnn_act_requant #(
    parameter int ACC_SIZE   = dnn_pkg::ACC_SIZE,
    parameter int OUT_SIZE   = dnn_pkg::OUT_SIZE,
    parameter int SHIFT      = dnn_pkg::SHIFT,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mac_ready,
    input  logic signed [ACC_SIZE-1:0] mac4,
    input  logic signed [ACC_SIZE-1:0] mac5,
    input  logic signed [ACC_SIZE-1:0] mac6,
    input  logic signed [ACC_SIZE-1:0] mac7,
    input  logic                       next_busy,
    output logic signed [OUT_SIZE-1:0] x0,
    output logic signed [OUT_SIZE-1:0] x1,
    output logic signed [OUT_SIZE-1:0] x2,
    output logic signed [OUT_SIZE-1:0] x3,
    output logic                       in_ready,
    output logic                       ovf,
    output logic [7:0]                 sat_cnt
);
    import dnn_pkg::*;

    localparam int AW = ACC_SIZE + 1;
    localparam int VW = LANES * OUT_SIZE;
    localparam logic [AW-1:0] RND  = AW'(1) << (SHIFT - 1);
    localparam logic [AW-1:0] QMAX = AW'((1 << (OUT_SIZE - 1)) - 1);

    logic                       s1_valid;
    logic signed [ACC_SIZE-1:0] s1_mac [LANES];
    logic [VW-1:0]              s2_vec;
    logic [LANES-1:0]           lane_sat;
    logic [2:0]                 sat_add;
    logic [8:0]                 sat_sum;
    logic [VW-1:0]              head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       pop;

    always_ff @(posedge clk) begin
        if (rst) s1_valid <= 1'b0;
        else     s1_valid <= mac_ready;
    end

    always_ff @(posedge clk) begin
        if (mac_ready) begin
            s1_mac[0] <= mac4;
            s1_mac[1] <= mac5;
            s1_mac[2] <= mac6;
            s1_mac[3] <= mac7;
        end
    end

    // S2 is combinational off S1 so the vector lands in the FIFO two edges after mac_ready
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [AW-1:0] r;
        logic [AW-1:0] q;
        assign r           = s1_mac[i][ACC_SIZE-1] ? '0 : {1'b0, s1_mac[i]};
        assign q           = (r + RND) >> SHIFT;
        assign lane_sat[i] = q > QMAX;
        assign s2_vec[i*OUT_SIZE +: OUT_SIZE] = lane_sat[i] ? QMAX[OUT_SIZE-1:0] : q[OUT_SIZE-1:0];
    end

    always_comb begin
        sat_add = '0;
        for (int i = 0; i < LANES; i++) sat_add = sat_add + 3'(lane_sat[i]);
    end

    assign sat_sum = {1'b0, sat_cnt} + 9'(sat_add);

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt <= '0;
            ovf     <= 1'b0;
        end else if (s1_valid) begin
            sat_cnt <= sat_sum[8] ? 8'hFF : sat_sum[7:0];
            if (fifo_full && !pop) ovf <= 1'b1;
        end
    end

    assign in_ready = !fifo_empty;
    assign pop      = in_ready && !next_busy;

    dnn_vec_fifo #(
        .WIDTH (VW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s1_valid),
        .pop   (pop),
        .din   (s2_vec),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign x0 = head[0*OUT_SIZE +: OUT_SIZE];
    assign x1 = head[1*OUT_SIZE +: OUT_SIZE];
    assign x2 = head[2*OUT_SIZE +: OUT_SIZE];
    assign x3 = head[3*OUT_SIZE +: OUT_SIZE];
endmodule

// File: tb/tb_dnn_act_requant.sv
// tb/tb_dnn_act_requant.sv - directed self-checking bench for dnn_act_requant
module tb_dnn_act_requant;
    logic               clk = 1'b0;
    logic               rst;
    logic               mac_ready;
    logic               next_busy;
    logic signed [16:0] mac4, mac5, mac6, mac7;
    logic signed [6:0]  x0, x1, x2, x3;
    logic               in_ready;
    logic               ovf;
    logic [7:0]         sat_cnt;
    logic [31:0]        xs;
    int                 n_checks = 0;
    int                 n_errors = 0;
    int                 pops;

    always #5 clk = ~clk;

    dnn_act_requant dut (
        .clk       (clk),
        .rst       (rst),
        .mac_ready (mac_ready),
        .mac4      (mac4),
        .mac5      (mac5),
        .mac6      (mac6),
        .mac7      (mac7),
        .next_busy (next_busy),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .in_ready  (in_ready),
        .ovf       (ovf),
        .sat_cnt   (sat_cnt)
    );

    assign xs = {4'b0, x0, x1, x2, x3};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] xv(input int a, input int b, input int c, input int d);
        return {4'b0, 7'(a), 7'(b), 7'(c), 7'(d)};
    endfunction

    task automatic drive(input int a, input int b, input int c, input int d);
        mac_ready = 1'b1;
        mac4 = 17'(a);
        mac5 = 17'(b);
        mac6 = 17'(c);
        mac7 = 17'(d);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        mac_ready = 1'b0;
        next_busy = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        mac4 = '0; mac5 = '0; mac6 = '0; mac7 = '0;
        do_reset;
        check("rst_in_ready", in_ready, 0);
        check("rst_ovf", ovf, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_x", xs, 0);

        // 100 -> (132>>6)=2, -5 -> 0, 95 -> 1, 96 -> 2
        drive(100, -5, 95, 96);
        tick;
        mac_ready = 1'b0;
        check("t1_latency", in_ready, 0);
        tick;
        check("t1_in_ready", in_ready, 1);
        check("t1_x", xs, xv(2, 0, 1, 2));
        tick;
        check("t1_popped", in_ready, 0);

        drive(65535, 4063, 4064, -65536);
        tick;
        mac_ready = 1'b0;
        tick;
        check("t2_in_ready", in_ready, 1);
        check("t2_x", xs, xv(63, 63, 63, 0));
        check("t2_sat_cnt", sat_cnt, 2);
        tick;
        check("t2_popped", in_ready, 0);

        // overflow drop: lane value 64*k requantizes to exactly k
        next_busy = 1'b1;
        drive(64, 128, 192, 256);
        tick;
        drive(320, 384, 448, 512);
        tick;
        check("t3_head_a", xs, xv(1, 2, 3, 4));
        drive(576, 640, 704, 768);
        tick;
        mac_ready = 1'b0;
        check("t3_ovf_pre", ovf, 0);
        tick;
        check("t3_ovf", ovf, 1);
        check("t3_hold_a", xs, xv(1, 2, 3, 4));
        check("t3_sat_cnt", sat_cnt, 2);
        next_busy = 1'b0;
        tick;
        check("t3_in_ready_b", in_ready, 1);
        check("t3_x_b", xs, xv(5, 6, 7, 8));
        tick;
        check("t3_c_dropped", in_ready, 0);
        check("t3_ovf_sticky", ovf, 1);

        do_reset;
        check("t4_rst_ovf", ovf, 0);
        check("t4_rst_sat", sat_cnt, 0);
        next_busy = 1'b1;
        drive(64, 128, 192, 256);
        tick;
        drive(320, 384, 448, 512);
        tick;
        drive(576, 640, 704, 768);
        tick;
        mac_ready = 1'b0;
        next_busy = 1'b0;
        check("t4_x_a", xs, xv(1, 2, 3, 4));
        tick;
        check("t4_x_b", xs, xv(5, 6, 7, 8));
        check("t4_ovf", ovf, 0);
        tick;
        check("t4_in_ready_c", in_ready, 1);
        check("t4_x_c", xs, xv(9, 10, 11, 12));
        tick;
        check("t4_empty", in_ready, 0);
        check("t4_ovf_end", ovf, 0);

        next_busy = 1'b1;
        drive(65535, 65535, 65535, 65535);
        tick;
        mac_ready = 1'b0;
        tick;
        check("t5_queued", in_ready, 1);
        check("t5_sat_pre", sat_cnt, 4);
        drive(65535, 65535, 65535, 65535);
        tick;
        rst = 1'b1;
        drive(64, 64, 64, 64);
        tick;
        check("t5_in_ready", in_ready, 0);
        check("t5_ovf", ovf, 0);
        check("t5_sat_cnt", sat_cnt, 0);
        check("t5_x", xs, 0);
        rst = 1'b0;
        mac_ready = 1'b0;
        next_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("t5_no_stale", in_ready, 0);
        end
        check("t5_sat_after", sat_cnt, 0);

        pops = 0;
        for (int i = 0; i < 75; i++) begin
            drive(65535, 65535, 65535, 65535);
            if (in_ready) begin
                pops++;
                check("t6_x", xs, xv(63, 63, 63, 63));
            end
            tick;
        end
        mac_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (in_ready) pops++;
            tick;
        end
        check("t6_pops", pops, 75);
        check("t6_sat_clamp", sat_cnt, 255);
        check("t6_ovf", ovf, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
